// File: rtl/aes_arb_pkg.sv
// Shared types and sizing helpers for the AES request arbiter.
package aes_arb_pkg;

  localparam int AES_BLK_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  // Watchdog counter must be able to hold the value TIMEOUT_CYCLES itself.
  function automatic int cnt_width(input int timeout_cycles);
    return (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after last_grant, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_idx,
  output logic [NUM_REQ-1:0] grant_onehot
);

  logic [ID_W-1:0] cand_s;

  // Scan priority order starting one past the previous winner.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand_s      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand_s = ID_W'((int'(last_grant) + off) % NUM_REQ);
      if (!grant_valid && req[cand_s]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_s;
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

  // One-hot form of the winning index.
  always_comb begin
    if (grant_valid) begin
      grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
    end else begin
      grant_onehot = '0;
    end
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one AES-128 core among NUM_REQ requesters with round-robin grant,
// tagged valid/ready response and a completion watchdog.
module aes_req_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*AES_BLK_W-1:0]   req_key_i,
  input  logic [NUM_REQ*AES_BLK_W-1:0]   req_pt_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [ID_W-1:0]                rsp_id_o,
  output logic [AES_BLK_W-1:0]           rsp_ct_o,
  output logic                           rsp_err_o,
  output logic                           aes_start_o,
  output logic [AES_BLK_W-1:0]           aes_key_o,
  output logic [AES_BLK_W-1:0]           aes_pt_o,
  input  logic                           aes_ready_i,
  input  logic                           aes_done_i,
  input  logic [AES_BLK_W-1:0]           aes_ct_i,
  output logic                           busy_o
);

  localparam int              CNT_W     = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(NUM_REQ - 1);

  arb_state_e             state_r;
  logic [ID_W-1:0]        last_grant_r;
  logic [ID_W-1:0]        id_r;
  logic [AES_BLK_W-1:0]   key_r;
  logic [AES_BLK_W-1:0]   pt_r;
  logic [AES_BLK_W-1:0]   ct_r;
  logic                   err_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   start_r;
  logic                   rsp_valid_r;
  logic                   busy_r;

  logic                   grant_valid_s;
  logic [ID_W-1:0]        grant_idx_s;
  logic [NUM_REQ-1:0]     grant_oh_s;
  logic                   grant_fire_s;
  logic [AES_BLK_W-1:0]   sel_key_s;
  logic [AES_BLK_W-1:0]   sel_pt_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req          (req_valid_i),
    .last_grant   (last_grant_r),
    .grant_valid  (grant_valid_s),
    .grant_idx    (grant_idx_s),
    .grant_onehot (grant_oh_s)
  );

  // Accept only from IDLE with an idle core; gating on rst_n keeps the strobe low in reset.
  assign grant_fire_s = rst_n && (state_r == ST_IDLE) && aes_ready_i && grant_valid_s;
  assign req_ready_o  = grant_fire_s ? grant_oh_s : {NUM_REQ{1'b0}};

  // Mux the winning requester's key and plaintext slices.
  always_comb begin
    sel_key_s = '0;
    sel_pt_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_key_s = (grant_idx_s == ID_W'(i)) ? req_key_i[i*AES_BLK_W +: AES_BLK_W] : sel_key_s;
      sel_pt_s  = (grant_idx_s == ID_W'(i)) ? req_pt_i[i*AES_BLK_W +: AES_BLK_W]  : sel_pt_s;
    end
  end

  // Main sequencer: IDLE -> ISSUE -> WAIT -> RESP -> IDLE, all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      last_grant_r <= LAST_INIT;
      id_r         <= '0;
      key_r        <= '0;
      pt_r         <= '0;
      ct_r         <= '0;
      err_r        <= 1'b0;
      cnt_r        <= '0;
      start_r      <= 1'b0;
      rsp_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_fire_s) begin
            key_r   <= sel_key_s;
            pt_r    <= sel_pt_s;
            id_r    <= grant_idx_s;
            start_r <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          start_r <= 1'b0;
          cnt_r   <= '0;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_r <= cnt_r + CNT_W'(1);
          // A done arriving in the final watchdog cycle still counts as success.
          if (aes_done_i) begin
            ct_r        <= aes_ct_i;
            err_r       <= 1'b0;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end else if (cnt_r == CNT_LAST) begin
            ct_r        <= '0;
            err_r       <= 1'b1;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            last_grant_r <= id_r;
            state_r      <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign aes_start_o = start_r;
  assign aes_key_o   = key_r;
  assign aes_pt_o    = pt_r;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_id_o    = id_r;
  assign rsp_ct_o    = ct_r;
  assign rsp_err_o   = err_r;
  assign busy_o      = busy_r;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Scoreboard bench for aes_req_arbiter with a stub AES core and a transaction-level model.
module tb_aes_req_arbiter;

  localparam int NUM_REQ        = 4;
  localparam int ID_W           = 2;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int BW             = 128;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h8df4e9aac5c7573a27d8d055d6e4d64b;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_REQ-1:0]      req_valid_i;
  logic [NUM_REQ*BW-1:0]   req_key_i;
  logic [NUM_REQ*BW-1:0]   req_pt_i;
  logic [NUM_REQ-1:0]      req_ready_o;
  logic                    rsp_valid_o;
  logic                    rsp_ready_i;
  logic [ID_W-1:0]         rsp_id_o;
  logic [BW-1:0]           rsp_ct_o;
  logic                    rsp_err_o;
  logic                    aes_start_o;
  logic [BW-1:0]           aes_key_o;
  logic [BW-1:0]           aes_pt_o;
  logic                    aes_ready_i;
  logic                    aes_done_i;
  logic [BW-1:0]           aes_ct_i;
  logic                    busy_o;

  aes_req_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .ID_W           (ID_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_key_i   (req_key_i),
    .req_pt_i    (req_pt_i),
    .req_ready_o (req_ready_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_id_o    (rsp_id_o),
    .rsp_ct_o    (rsp_ct_o),
    .rsp_err_o   (rsp_err_o),
    .aes_start_o (aes_start_o),
    .aes_key_o   (aes_key_o),
    .aes_pt_o    (aes_pt_o),
    .aes_ready_i (aes_ready_i),
    .aes_done_i  (aes_done_i),
    .aes_ct_i    (aes_ct_i),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_starts = 0;

  typedef struct {
    int           id;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];
  exp_t m_e;
  int   m_phase = 0;   // 0 idle, 1 issue, 2 wait, 3 respond
  int   m_last = NUM_REQ - 1;
  int   m_wait = 0;
  int   m_start_cyc = 0;
  int   m_g = 0;
  logic m_resp_first = 1'b0;
  logic [NUM_REQ-1:0] acc_mask = '0;
  logic hang_req = 1'b0;
  logic cur_hang = 1'b0;
  int   force_lat = 0;
  logic spur_done = 1'b0;

  // Stub core: known-answer vectors, otherwise a fixed scramble of key and plaintext.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
    if (k == K1 && p == PT) return C1;
    if (k == K2 && p == PT) return C2;
    return {k[63:0], p[127:64]} ^ {p[63:0], k[127:64]} ^ 128'h5a5a_0000_ffff_1234_0f0f_aaaa_3c3c_9999;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stub AES core sharing rst_n; done latency 1..15 cycles, or never when hung.
  logic [4:0]   stub_cnt;
  logic         stub_done;
  logic [127:0] stub_key, stub_pt, stub_ct;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_cnt <= '0; stub_done <= 1'b0; stub_ct <= '0; stub_key <= '0; stub_pt <= '0;
    end else begin
      stub_done <= 1'b0;
      if (aes_start_o && !cur_hang) begin
        stub_cnt <= (force_lat > 0) ? 5'(force_lat) : 5'($urandom_range(1, 15));
        stub_key <= aes_key_o;
        stub_pt  <= aes_pt_o;
      end else if (stub_cnt == 5'd1) begin
        stub_cnt  <= '0;
        stub_done <= 1'b1;
        stub_ct   <= core_fn(stub_key, stub_pt);
      end else if (stub_cnt > 5'd1) begin
        stub_cnt <= stub_cnt - 5'd1;
      end
    end
  end
  assign aes_done_i = stub_done | spur_done;
  assign aes_ct_i   = stub_ct;

  // Reference model and monitor: predicts grants, pushes expectations, pops on handshake.
  always @(negedge clk) begin
    cyc++;
    acc_mask = '0;
    if (aes_start_o) n_starts++;
    if (!rst_n) begin
      m_phase = 0;
      m_last  = NUM_REQ - 1;
      exp_q.delete();
    end else begin
      check("busy_o", busy_o, m_phase != 0);
      check("rsp_valid_o", rsp_valid_o, m_phase == 3);
      check("aes_start_o", aes_start_o, m_phase == 1);
      if (m_phase != 0) check("req_ready_busy", req_ready_o, '0);
      case (m_phase)
        0: begin
          m_g = -1;
          if (aes_ready_i) begin
            for (int k = 1; k <= NUM_REQ; k++)
              if (m_g < 0 && req_valid_i[(m_last + k) % NUM_REQ]) m_g = (m_last + k) % NUM_REQ;
          end
          if (m_g < 0) begin
            check("req_ready_idle", req_ready_o, '0);
          end else begin
            check("req_ready_grant", req_ready_o, 1 << m_g);
            m_e.id  = m_g;
            m_e.key = req_key_i[m_g*BW +: BW];
            m_e.pt  = req_pt_i[m_g*BW +: BW];
            m_e.err = hang_req;
            m_e.ct  = hang_req ? 128'd0 : core_fn(m_e.key, m_e.pt);
            exp_q.push_back(m_e);
            grant_log.push_back(m_g);
            cur_hang = hang_req;
            acc_mask[m_g] = 1'b1;
            m_phase = 1;
          end
        end
        1, 2: begin
          if (exp_q.size() > 0) begin
            check("aes_key_o", aes_key_o, exp_q[0].key);
            check("aes_pt_o", aes_pt_o, exp_q[0].pt);
          end
          if (m_phase == 1) begin
            m_start_cyc = cyc;
            m_wait = 0;
            m_phase = 2;
          end else begin
            m_wait++;
            if (aes_done_i || m_wait == TIMEOUT_CYCLES) begin
              m_phase = 3;
              m_resp_first = 1'b1;
            end
          end
        end
        3: begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard: response with empty queue (cycle %0d)", cyc);
            m_phase = 0;
          end else begin
            check("rsp_id_o", rsp_id_o, exp_q[0].id);
            check("rsp_ct_o", rsp_ct_o, exp_q[0].ct);
            check("rsp_err_o", rsp_err_o, exp_q[0].err);
            if (m_resp_first && exp_q[0].err) check("timeout_latency", cyc - m_start_cyc, TIMEOUT_CYCLES + 1);
            m_resp_first = 1'b0;
            if (rsp_ready_i) begin
              m_last = exp_q[0].id;
              void'(exp_q.pop_front());
              m_phase = 0;
            end
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic step();
    @(posedge clk); #1;
    req_valid_i = req_valid_i & ~acc_mask;
  endtask

  task automatic set_req(input int i, input logic [127:0] k, input logic [127:0] p);
    req_key_i[i*BW +: BW] = k;
    req_pt_i[i*BW +: BW]  = p;
    req_valid_i[i] = 1'b1;
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while (!(req_valid_i == '0 && m_phase == 0 && exp_q.size() == 0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s: not drained after %0d cycles, phase %0d", name, n, m_phase);
    end
  endtask

  task automatic wait_phase(input int ph, input int budget, input string name);
    int n = 0;
    while (m_phase != ph && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s: phase %0d not reached, at %0d", name, ph, m_phase);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_req_ready"}, req_ready_o, '0);
    check({name, "_rsp_valid"}, rsp_valid_o, '0);
    check({name, "_rsp_id"}, rsp_id_o, '0);
    check({name, "_rsp_ct"}, rsp_ct_o, '0);
    check({name, "_rsp_err"}, rsp_err_o, '0);
    check({name, "_start"}, aes_start_o, '0);
    check({name, "_key"}, aes_key_o, '0);
    check({name, "_pt"}, aes_pt_o, '0);
    check({name, "_busy"}, busy_o, '0);
  endtask

  task automatic pulse_reset(input string name);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_all_zero(name);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
  end

  initial begin
    int s0, g0;
    rst_n = 1'b0; req_valid_i = '0; req_key_i = '0; req_pt_i = '0;
    rsp_ready_i = 1'b1; aes_ready_i = 1'b1;
    #2;
    check_all_zero("reset");
    #20;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single request on requester 0.
    set_req(0, K1, PT);
    drain(60, "single");
    check("single_starts", n_starts, 1);
    check("single_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);

    // All four valid straight out of reset.
    pulse_reset("reset2");
    grant_log.delete();
    set_req(0, rand128(), rand128());
    set_req(1, rand128(), rand128());
    set_req(2, K2, PT);
    set_req(3, rand128(), rand128());
    drain(200, "all_four");
    check("order_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) check("grant_order", grant_log[i], i);

    // Held-off response consumer.
    rsp_ready_i = 1'b0;
    set_req(1, rand128(), rand128());
    wait_phase(3, 60, "bp_resp");
    s0 = n_starts;
    set_req(0, rand128(), rand128());
    set_req(2, rand128(), rand128());
    repeat (50) step();
    check("bp_no_start", n_starts - s0, 0);
    rsp_ready_i = 1'b1;
    drain(200, "bp_drain");

    // Watchdog timeout, then a normal request; then done on the final watchdog cycle.
    hang_req = 1'b1;
    set_req(3, rand128(), rand128());
    drain(80, "timeout");
    hang_req = 1'b0;
    set_req(0, K1, PT);
    drain(60, "after_timeout");
    force_lat = 15;
    set_req(2, rand128(), rand128());
    drain(60, "done_at_limit");
    force_lat = 0;

    // Reset while waiting on a hung core.
    hang_req = 1'b1;
    set_req(1, rand128(), rand128());
    wait_phase(2, 20, "rst_wait");
    repeat (3) step();
    req_valid_i = 4'b0101;
    pulse_reset("reset_wait");
    hang_req = 1'b0;
    grant_log.delete();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, rand128(), rand128());
    drain(200, "post_reset");
    check("post_reset_first", grant_log.size() > 0 ? grant_log[0] : -1, 0);

    // Core not ready, spurious done in IDLE, then grant on the first ready cycle.
    aes_ready_i = 1'b0;
    g0 = grant_log.size();
    set_req(1, rand128(), rand128());
    repeat (5) step();
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    step();
    check("not_ready_grants", grant_log.size() - g0, 0);
    aes_ready_i = 1'b1;
    step();
    check("first_ready_grant", grant_log.size() - g0, 1);
    drain(60, "ready_drain");

    // Randomized traffic.
    for (int t = 0; t < 600; t++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc_mask[i] || !req_valid_i[i]) begin
          req_valid_i[i] = ($urandom_range(0, 2) == 0);
          req_key_i[i*BW +: BW] = rand128();
          req_pt_i[i*BW +: BW]  = rand128();
        end else if ($urandom_range(0, 9) == 0) begin
          req_valid_i[i] = 1'b0;
        end
      end
      aes_ready_i = ($urandom_range(0, 9) != 0);
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      hang_req    = ($urandom_range(0, 11) == 0);
    end
    aes_ready_i = 1'b1; rsp_ready_i = 1'b1; hang_req = 1'b0;
    drain(600, "final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
